// File: rtl/rll_key_loader.sv
// rll_key_loader: serial-to-parallel key delivery for RLL-locked netlists.
// Receives KEY_W key bits LSB first followed by one even-parity bit, and
// commits the key to key_out on a single clock edge only when parity checks.
// Until a checked key is committed, key_out carries the DECOY value.
// Optional feature: define KEY_LOCKOUT_EN to enable a lockout after MAX_FAIL
// consecutive parity failures (released only by rst_n).
module rll_key_loader #(
  parameter int               KEY_W    = 16,
  parameter logic [KEY_W-1:0] DECOY    = '0,
  parameter int               MAX_FAIL = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_start,
  input  logic             s_valid,
  input  logic             s_data,
  output logic             s_ready,
  input  logic             clear,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             busy,
  output logic             err,
  output logic             locked_out
);

  localparam int CNT_W = $clog2(KEY_W + 2);
  localparam int IDX_W = (KEY_W > 1) ? $clog2(KEY_W) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [KEY_W-1:0] shadow;
  logic [CNT_W-1:0] cnt;
  logic             par_bit;
  logic             accept;
  logic             start_ok;
  logic             restart;
  logic             parity_ok;
  logic             lock_active;

  // Even parity: the key bits plus the parity bit must hold an even count of ones
  assign parity_ok = ((^shadow) == par_bit);

`ifdef KEY_LOCKOUT_EN
  localparam int FAIL_W = (MAX_FAIL > 0) ? $clog2(MAX_FAIL + 1) : 1;

  logic [FAIL_W-1:0] fail_cnt;
  logic              locked;

  assign lock_active = locked;
  assign locked_out  = locked;

  // Count consecutive parity failures; lock once MAX_FAIL is reached (only rst_n releases)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_cnt <= '0;
      locked   <= 1'b0;
    end else if (state == CHECK && !clear) begin
      if (parity_ok) begin
        fail_cnt <= '0;
      end else if (fail_cnt != FAIL_W'(MAX_FAIL)) begin
        fail_cnt <= fail_cnt + FAIL_W'(1);
        if (fail_cnt == FAIL_W'(MAX_FAIL - 1)) begin
          locked <= 1'b1;
        end
      end
    end
  end
`else
  logic unused_cfg;

  assign lock_active = 1'b0;
  assign locked_out  = 1'b0;
  assign unused_cfg  = (MAX_FAIL != 0);
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake decode; clear overrides everything and aborts any load
  always_comb begin
    state_next = state;
    s_ready    = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    start_ok   = 1'b0;
    restart    = 1'b0;
    case (state)
      IDLE: begin
        if (load_start && !lock_active) begin
          start_ok   = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (load_start) begin
          restart = 1'b1;
        end else if (s_valid) begin
          accept = 1'b1;
          if (cnt == CNT_W'(KEY_W)) begin
            state_next = CHECK;
          end
        end
      end
      CHECK: begin
        busy       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (clear) begin
      state_next = IDLE;
      accept     = 1'b0;
      start_ok   = 1'b0;
      restart    = 1'b0;
    end
  end

  // Shadow fill, bit counting and the single-edge commit of the checked key
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow    <= '0;
      cnt       <= '0;
      par_bit   <= 1'b0;
      key_out   <= DECOY;
      key_valid <= 1'b0;
      err       <= 1'b0;
    end else if (clear) begin
      shadow    <= '0;
      cnt       <= '0;
      key_out   <= DECOY;
      key_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (start_ok || restart) begin
        shadow <= '0;
        cnt    <= '0;
        err    <= 1'b0;
      end else if (accept) begin
        if (cnt < CNT_W'(KEY_W)) begin
          shadow[cnt[IDX_W-1:0]] <= s_data;
        end else begin
          par_bit <= s_data;
        end
        cnt <= cnt + CNT_W'(1);
      end
      if (state == CHECK) begin
        if (parity_ok) begin
          key_out   <= shadow;
          key_valid <= 1'b1;
        end else begin
          key_out   <= DECOY;
          key_valid <= 1'b0;
          err       <= 1'b1;
        end
      end
    end
  end

endmodule
